// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line levels and default frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  localparam int DEF_DW        = 8;
  localparam int DEF_SLOOP_MAX = 15;

endpackage

// File: rtl/uart_rx_recv_sync_2ff.sv
// Two-flop synchroniser for the asynchronous RX line; resets to the idle line level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_recv.sv
// UART receiver: mid-bit sampling deframer with a one-entry output register.
// Handshake: valid=1 means dout holds an unread byte; ren while valid=1 consumes it on the next edge.
module uart_rx_recv
  import uart_pkg::*;
#(
  parameter int SLOOP_MAX = DEF_SLOOP_MAX,
  parameter int DW        = DEF_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RX,
  input  logic          ren,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          ferr,
  output logic          ovr,
  output logic [2:0]    dbg_state
);

  localparam int SW = (SLOOP_MAX > 0) ? $clog2(SLOOP_MAX + 1) : 1;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [SW-1:0] HALF  = SW'(SLOOP_MAX / 2);
  localparam logic [SW-1:0] SMAX  = SW'(SLOOP_MAX);
  localparam logic [BW-1:0] BLAST = BW'(DW - 1);

  logic          rx_s;
  state_t        state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          frame_done;

  sync_2ff #(.RST_VAL(IDLE_LVL)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (RX),
    .q   (rx_s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    dout_d     = dout_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    frame_done = 1'b0;

    if (ren && valid_q) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_s == START_LVL) begin
          state_d = START;
          scnt_d  = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in so short low glitches are rejected.
        if (scnt_q == HALF) begin
          if (rx_s != START_LVL) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            scnt_d  = '0;
            bcnt_d  = '0;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      DATA: begin
        if (scnt_q == SMAX) begin
          scnt_d          = '0;
          shreg_d[bcnt_q] = rx_s;
          if (bcnt_q == BLAST) state_d = STOP;
          else                 bcnt_d  = bcnt_q + 1'b1;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      STOP: begin
        if (scnt_q == SMAX) begin
          scnt_d = '0;
          if (rx_s == STOP_LVL) begin
            state_d    = IDLE;
            frame_done = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s == IDLE_LVL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A read in the completion cycle frees the slot, so the new byte replaces the old one.
    if (frame_done) begin
      if (!valid_q || ren) begin
        dout_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign ferr      = ferr_q;
  assign ovr       = ovr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_recv.sv
// Bench for uart_rx_recv: serial frames driven bit by bit, received bytes checked against an expected queue.
module tb_uart_rx_recv;
  import uart_pkg::*;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       ren = 1'b0;
  logic [7:0] dout;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int val_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_recv #(.SLOOP_MAX(15), .DW(8)) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX        (rx),
    .ren       (ren),
    .dout      (dout),
    .valid     (valid),
    .ferr      (ferr),
    .ovr       (ovr),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (N) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop);
  endtask

  task automatic read_byte();
    ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    check("read_clears_valid", valid, 1'b0);
  endtask

  // Scoreboard: a new byte is either a rising valid or a dout change while valid stays high.
  logic       prev_valid = 1'b0;
  logic [7:0] prev_dout = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      if (ferr) ferr_cnt++;
      if (ovr)  ovr_cnt++;
      if (valid && (!prev_valid || dout != prev_dout)) begin
        val_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", dout, $time);
        end else begin
          check("rx_byte", dout, exp_q.pop_front());
        end
      end
    end
    prev_valid = valid;
    prev_dout  = dout;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    int f0, v0, o0;

    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hAA, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'hC3, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};

    repeat (3) @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", ferr, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Loopback-style table with the reader always ready.
    ren = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f0 = ferr_cnt; v0 = val_cnt; o0 = ovr_cnt;
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check("tbl_valid_cnt", val_cnt - v0, vecs[i].exp_valid);
      check("tbl_ferr_cnt", ferr_cnt - f0, vecs[i].exp_ferr);
      check("tbl_ovr_cnt", ovr_cnt - o0, 0);
      check("tbl_valid_low", valid, 1'b0);
    end
    ren = 1'b0;

    // Latency from the first edge that captures RX low.
    exp_q.push_back(8'hA3);
    lat = -1;
    fork
      send_frame(8'hA3, 1'b1);
      begin
        for (int k = 0; k < 400 && lat < 0; k++) begin
          @(posedge clk);
          #1;
          if (valid) lat = k;
        end
      end
    join
    check("latency", lat, 154);
    check("lat_dout", dout, 8'hA3);
    repeat (30) @(negedge clk);
    check("lat_valid_held", valid, 1'b1);
    read_byte();

    // Glitch shorter than half a bit.
    f0 = ferr_cnt; v0 = val_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_state", dbg_state, IDLE);
    check("glitch_no_valid", val_cnt - v0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    check("glitch_next_dout", dout, 8'h3C);
    read_byte();

    // Framing error followed by a long break.
    f0 = ferr_cnt; v0 = val_cnt;
    send_frame(8'h0F, 1'b0);
    repeat (300) @(negedge clk);
    check("ferr_once", ferr_cnt - f0, 1);
    check("ferr_no_valid", val_cnt - v0, 0);
    check("ferr_valid_low", valid, 1'b0);
    check("ferr_wait_high", dbg_state, WAIT_HIGH);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (10) @(negedge clk);
    check("ferr_next_dout", dout, 8'h81);
    read_byte();

    // Overrun: back-to-back frames with nobody reading.
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    check("ovr_once", ovr_cnt - o0, 1);
    check("ovr_dout_kept", dout, 8'h11);
    check("ovr_valid", valid, 1'b1);
    read_byte();

    // Read on the exact completion cycle of the second frame.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    repeat (5) @(negedge clk);
    o0 = ovr_cnt;
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (154) @(negedge clk);
        ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("simul_dout", dout, 8'h22);
    check("simul_valid", valid, 1'b1);
    check("simul_no_ovr", ovr_cnt - o0, 0);
    read_byte();

    // Reset during data bit 4 while an unread byte is held.
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    repeat (5) @(negedge clk);
    check("pre_rst_valid", valid, 1'b1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (88) @(negedge clk);
        check("pre_rst_state", dbg_state, DATA);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", valid, 1'b0);
        check("midrst_dout", dout, 8'h00);
        check("midrst_ferr", ferr, 1'b0);
        check("midrst_ovr", ovr, 1'b0);
        check("midrst_state", dbg_state, IDLE);
        rst = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("post_rst_valid", valid, 1'b0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    check("post_rst_dout", dout, 8'h5A);
    read_byte();

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_state", dbg_state, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
